morse_sequencer: RTL and testbench

Letter-queue controller for the Morse LED output. It accepts 3-bit letter codes (S..Z) through a valid/ready handshake and buffers them in a small FIFO. It then plays each letter on a single output line at a fixed unit rate, inserting an inter-letter gap between letters. It replaces manual per-letter load/enable sequencing of the pattern shifter, and sits between the board switches/keys (or a host) and the LED.

---
 rtl/morse_sequencer.sv | 161 ++++++++++++++++
 tb/tb_morse_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_sequencer.sv
// rtl/morse_sequencer.sv - letter FIFO feeding a Morse pattern player with inter-letter gaps
module morse_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_UNITS  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [2:0]                    in_letter,
    output logic                          in_ready,
    input  logic                          abort,
    output logic                          out,
    output logic                          busy,
    output logic                          letter_done,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int GAP_W = $clog2(GAP_UNITS + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_UNITS);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SYM, GAP} state_t;

    state_t             state, state_next;
    logic [12:0]        shreg, shreg_next;
    logic [3:0]         len, len_next;
    logic [DIV_W-1:0]   div, div_next;
    logic [GAP_W-1:0]   gap, gap_next;
    logic               out_next, done_next;
    logic               tick, push, pop;

    logic [2:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;

    // {length in units, pattern LSB first}
    function automatic logic [16:0] rom(input logic [2:0] letter);
        case (letter)
            3'd0:    return {4'd5,  13'h0015};
            3'd1:    return {4'd3,  13'h0007};
            3'd2:    return {4'd7,  13'h0075};
            3'd3:    return {4'd9,  13'h01D5};
            3'd4:    return {4'd9,  13'h01DD};
            3'd5:    return {4'd11, 13'h0757};
            3'd6:    return {4'd13, 13'h1DD7};
            default: return {4'd11, 13'h0577};
        endcase
    endfunction

    assign in_ready = (count != FULL_COUNT);
    assign push     = in_valid && in_ready && !abort;
    assign busy     = (state != IDLE) || (count != '0);
    assign level    = count;
    assign tick     = (div == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_letter;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        len_next   = len;
        div_next   = div;
        gap_next   = gap;
        done_next  = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop                    = 1'b1;
                    {len_next, shreg_next} = rom(mem[rd_ptr]);
                    div_next               = DIV_RELOAD;
                    state_next             = SYM;
                end
            end
            SYM: begin
                if (tick) begin
                    div_next = DIV_RELOAD;
                    if (len == 4'd1) begin
                        state_next = GAP;
                        gap_next   = GAP_RELOAD;
                    end else begin
                        shreg_next = shreg >> 1;
                        len_next   = len - 4'd1;
                    end
                end else begin
                    div_next = div - 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    div_next = DIV_RELOAD;
                    if (gap == GAP_W'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        gap_next = gap - 1'b1;
                    end
                end else begin
                    div_next = div - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            done_next  = 1'b0;
            pop        = 1'b0;
        end
        // out is registered from the next state so it changes on the same edge as the unit
        out_next = (state_next == SYM) && shreg_next[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            len         <= '0;
            div         <= '0;
            gap         <= '0;
            out         <= 1'b0;
            letter_done <= 1'b0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            len         <= len_next;
            div         <= div_next;
            gap         <= gap_next;
            out         <= out_next;
            letter_done <= done_next;
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// tb/tb_morse_sequencer.sv - randomized and directed self-checking bench for morse_sequencer
module tb_morse_sequencer;
    localparam int TD    = 4;
    localparam int DEPTH = 4;
    localparam int GAPU  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_letter = 3'd0;
    logic       abort = 1'b0;
    logic       in_ready, out, busy, letter_done;
    logic [2:0] level;

    morse_sequencer #(.TICK_DIV(TD), .FIFO_DEPTH(DEPTH), .GAP_UNITS(GAPU)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_letter(in_letter),
        .in_ready(in_ready), .abort(abort), .out(out), .busy(busy),
        .letter_done(letter_done), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int pat [8] = '{'h15, 'h7, 'h75, 'h1D5, 'h1DD, 'h757, 'h1DD7, 'h577};
    int plen[8] = '{5, 3, 7, 9, 9, 11, 13, 11};

    // Model: a letter is a timeline of (L+GAP)*TD cycles indexed by t since load
    int q[$];
    bit playing = 0;
    int t = 0;
    int cur = 0;
    bit m_done = 0;
    int rec[$];

    function automatic int m_out();
        if (!playing || (t / TD) >= plen[cur]) return 0;
        return (pat[cur] >> (t / TD)) & 1;
    endfunction

    task automatic model_clear();
        q.delete();
        playing = 0;
        m_done  = 0;
    endtask

    task automatic model_edge();
        bit push;
        if (reset || abort) begin
            model_clear();
            return;
        end
        push   = in_valid && (q.size() < DEPTH);
        m_done = 0;
        if (playing) begin
            t++;
            if (t == (plen[cur] + GAPU) * TD) begin
                playing = 0;
                m_done  = 1;
            end
        end else if (q.size() > 0) begin
            cur     = q.pop_front();
            playing = 1;
            t       = 0;
        end
        if (push) q.push_back(int'(in_letter));
    endtask

    task automatic check(string name, logic [31:0] act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(string name, string act, string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("out", out, m_out());
        check("in_ready", in_ready, int'(q.size() < DEPTH));
        check("busy", busy, int'(playing || q.size() > 0));
        check("letter_done", letter_done, int'(m_done));
        check("level", level, q.size());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    function automatic string rle(int b[$]);
        string s = "";
        int n = 0;
        for (int i = 0; i < b.size(); i++) begin
            n++;
            if (i == b.size() - 1 || b[i+1] != b[i]) begin
                s = {s, $sformatf("%0d%s", n, b[i] ? "H" : "L")};
                n = 0;
            end
        end
        return s;
    endfunction

    function automatic string model_rle(int l);
        int b[$];
        for (int k = 0; k < (plen[l] + GAPU) * TD; k++)
            b.push_back(((k / TD) < plen[l]) ? ((pat[l] >> (k / TD)) & 1) : 0);
        return rle(b);
    endfunction

    task automatic play(int letter, string exp, string name);
        bit ok = 0;
        in_valid  = 1'b1;
        in_letter = 3'(letter);
        cycle();
        in_valid = 1'b0;
        rec.delete();
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (letter_done) begin
                ok = 1;
                break;
            end
            rec.push_back(int'(out));
        end
        check(name, ok, 1);
        check_str(name, rle(rec), exp);
    endtask

    task automatic drain(string name);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        check_str("model_Y", model_rle(6), "12H4L4H4L12H4L12H12L");
        check_str("model_T", model_rle(1), "12H12L");

        cycle();
        cycle();
        reset = 1'b0;
        check("reset_ready", in_ready, 1);
        check("reset_level", level, 0);
        cycle();

        play(1, "12H12L", "play_T");
        check("busy_after_T", busy, 0);
        cycle();
        play(2, "4H4L4H4L12H12L", "play_U");
        play(6, "12H4L4H4L12H4L12H12L", "play_Y");
        cycle();

        // five back-to-back pushes, the sixth is held off by a full queue
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_letter = 3'((i * 3 + 1) % 8);
            cycle();
            if (i == 1) check("pushpop_level", level, 1);
        end
        check("full_level", level, DEPTH);
        check("full_ready", in_ready, 0);
        in_letter = 3'd7;
        begin
            bit acc = 0;
            for (int i = 0; i < 500; i++) begin
                if (in_ready) acc = 1;
                cycle();
                if (acc) break;
            end
            check("sixth_accepted", acc, 1);
        end
        in_valid = 1'b0;
        drain("drain_b2b");

        // abort during the second unit of X with two letters queued
        in_valid = 1'b1; in_letter = 3'd5; cycle();
        in_letter = 3'd3; cycle();
        in_letter = 3'd4; cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("pre_abort_level", level, 2);
        abort = 1'b1; in_valid = 1'b1; in_letter = 3'd0;
        cycle();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_out", out, 0);
        check("abort_level", level, 0);
        check("abort_busy", busy, 0);
        check("abort_done", letter_done, 0);
        cycle();
        play(0, "4H4L4H4L4H12L", "play_S");

        // async reset in the middle of T's dash
        in_valid = 1'b1; in_letter = 3'd1; cycle();
        in_letter = 3'd2; cycle();
        in_letter = 3'd3; cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("pre_reset_out", out, 1);
        #2 reset = 1'b1;
        #1;
        check("areset_out", out, 0);
        check("areset_level", level, 0);
        check("areset_ready", in_ready, 1);
        model_clear();
        cycle();
        reset = 1'b0;
        cycle();
        play(7, "12H4L12H4L4H4L4H12L", "play_Z");

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_letter = 3'($urandom_range(0, 7));
            abort     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
